uart_tx_buf: RTL

Transmit end of the keyboard-to-monitor UART link: the writer-side counterpart of the receive flag buffer.
- A one-word holding register with a full flag accepts a byte from the producer (keyboard scan-code path).
- A 16x-oversampled transmitter FSM drains the byte and serialises it onto the tx line.
- The producer checks tx_full before writing, just as the consumer checks the receive-side flag.

---
 rtl/uart_tx_buf.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// UART transmitter with a one-word holding buffer and 16x-oversampled serialiser.
// Optional even-parity bit between data and stop when TX_PARITY_EN is defined.
module uart_tx_buf #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_full,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW   = $clog2(TMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shift_q;
  logic [DBIT-1:0] hold_q;
  logic            full_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
`ifdef TX_PARITY_EN
  logic            par_q;
`endif

  logic wr_accept;
  assign wr_accept = wr && !full_q;

  // tx/busy/done are computed for the state being entered, so outputs are plain flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (wr_accept) begin
        hold_q <= din;
        full_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (full_q) begin
            shift_q <= hold_q;
            full_q  <= 1'b0;
            s_q     <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
`ifdef TX_PARITY_EN
            par_q   <= ^hold_q;
`endif
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_q == TW'(15)) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= shift_q[0];
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_q == TW'(15)) begin
              s_q     <= '0;
              shift_q <= shift_q >> 1;
              if (n_q == NW'(DBIT - 1)) begin
`ifdef TX_PARITY_EN
                tx_q    <= par_q;
                state_q <= ST_PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
`endif
              end else begin
                n_q  <= n_q + NW'(1);
                tx_q <= shift_q[1];
              end
            end else begin
              s_q <= s_q + TW'(1);
            end
          end
        end
`ifdef TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_q == TW'(15)) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + TW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (s_q == TW'(SB_TICK - 1)) begin
              s_q     <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + TW'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_full      = full_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
